// File: rtl/csr_commit_ctrl.sv
// Commit-side CSR controller: issues one regfile request for the CSR op at the
// scoreboard head, retires or faults it, and requests a flush after side-effect writes.
module csr_commit_ctrl #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            instr_valid_i,
   input  logic [1:0]      instr_op_i,
   input  logic [XLEN-1:0] instr_wdata_i,
   input  logic [4:0]      instr_rd_i,
   input  logic [11:0]     csr_addr_i,
   output logic            csr_commit_o,
   output logic            csr_req_o,
   output logic [11:0]     csr_addr_o,
   output logic [1:0]      csr_op_o,
   output logic [XLEN-1:0] csr_wdata_o,
   input  logic            csr_rsp_valid_i,
   input  logic [XLEN-1:0] csr_rdata_i,
   input  logic            csr_exc_i,
   output logic            wb_valid_o,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic            commit_ack_o,
   output logic            exception_o,
   output logic            exc_timeout_o,
   output logic            flush_pipe_o
);

   localparam int unsigned     CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_SET   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DONE  = 2'd2,
      FENCE = 2'd3
   } state_e;

   function automatic logic has_write_effect(input logic [1:0] op, input logic [XLEN-1:0] wdata);
      return (op == OP_WRITE) ||
             (((op == OP_SET) || (op == OP_CLEAR)) && (wdata != {XLEN{1'b0}}));
   endfunction

   function automatic logic is_side_effect_addr(input logic [11:0] addr);
      return (addr == 12'h180) || (addr == 12'h300) || (addr[11:4] == 8'h7C);
   endfunction

   state_e            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        op_r;
   logic [11:0]       addr_r;
   logic [XLEN-1:0]   wdata_r;
   logic [4:0]        rd_r;
   logic              csr_req_r;
   logic              csr_commit_r;
   logic              commit_ack_r;
   logic              wb_valid_r;
   logic [4:0]        wb_rd_r;
   logic [XLEN-1:0]   wb_data_r;
   logic              exception_r;
   logic              exc_timeout_r;
   logic              flush_pipe_r;

   // Control FSM: the DONE pulses are loaded on the REQ->DONE edge and live for one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         op_r          <= 2'd0;
         addr_r        <= 12'd0;
         wdata_r       <= {XLEN{1'b0}};
         rd_r          <= 5'd0;
         csr_req_r     <= 1'b0;
         csr_commit_r  <= 1'b0;
         commit_ack_r  <= 1'b0;
         wb_valid_r    <= 1'b0;
         wb_rd_r       <= 5'd0;
         wb_data_r     <= {XLEN{1'b0}};
         exception_r   <= 1'b0;
         exc_timeout_r <= 1'b0;
         flush_pipe_r  <= 1'b0;
      end else begin
         csr_commit_r  <= 1'b0;
         commit_ack_r  <= 1'b0;
         wb_valid_r    <= 1'b0;
         exception_r   <= 1'b0;
         exc_timeout_r <= 1'b0;
         flush_pipe_r  <= 1'b0;
         if (flush_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            csr_req_r <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (instr_valid_i) begin
                     op_r      <= instr_op_i;
                     addr_r    <= csr_addr_i;
                     wdata_r   <= instr_wdata_i;
                     rd_r      <= instr_rd_i;
                     cnt_r     <= '0;
                     csr_req_r <= 1'b1;
                     state_r   <= REQ;
                  end
               end
               REQ: begin
                  if (csr_rsp_valid_i) begin
                     csr_req_r <= 1'b0;
                     state_r   <= DONE;
                     wb_rd_r   <= rd_r;
                     wb_data_r <= csr_rdata_i;
                     if (csr_exc_i) begin
                        exception_r <= 1'b1;
                     end else begin
                        csr_commit_r <= 1'b1;
                        commit_ack_r <= 1'b1;
                        wb_valid_r   <= (rd_r != 5'd0);
                        flush_pipe_r <= has_write_effect(op_r, wdata_r) &&
                                        is_side_effect_addr(addr_r);
                     end
                  end else if (cnt_r == CNT_MAX) begin
                     csr_req_r     <= 1'b0;
                     state_r       <= DONE;
                     exception_r   <= 1'b1;
                     exc_timeout_r <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
               DONE: begin
                  state_r <= flush_pipe_r ? FENCE : IDLE;
               end
               FENCE: begin
                  state_r <= FENCE;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   // A flush landing on the DONE cycle cancels that cycle's pulses.
   assign csr_commit_o  = csr_commit_r  & ~flush_i;
   assign commit_ack_o  = commit_ack_r  & ~flush_i;
   assign wb_valid_o    = wb_valid_r    & ~flush_i;
   assign exception_o   = exception_r   & ~flush_i;
   assign exc_timeout_o = exc_timeout_r & ~flush_i;
   assign flush_pipe_o  = flush_pipe_r  & ~flush_i;

   assign csr_req_o   = csr_req_r;
   assign csr_addr_o  = addr_r;
   assign csr_op_o    = op_r;
   assign csr_wdata_o = wdata_r;
   assign wb_rd_o     = wb_rd_r;
   assign wb_data_o   = wb_data_r;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed bench for csr_commit_ctrl with TIMEOUT=8.
module tb_csr_commit_ctrl;

   localparam int XLEN    = 64;
   localparam int TIMEOUT = 8;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            instr_valid_i;
   logic [1:0]      instr_op_i;
   logic [XLEN-1:0] instr_wdata_i;
   logic [4:0]      instr_rd_i;
   logic [11:0]     csr_addr_i;
   logic            csr_commit_o;
   logic            csr_req_o;
   logic [11:0]     csr_addr_o;
   logic [1:0]      csr_op_o;
   logic [XLEN-1:0] csr_wdata_o;
   logic            csr_rsp_valid_i;
   logic [XLEN-1:0] csr_rdata_i;
   logic            csr_exc_i;
   logic            wb_valid_o;
   logic [4:0]      wb_rd_o;
   logic [XLEN-1:0] wb_data_o;
   logic            commit_ack_o;
   logic            exception_o;
   logic            exc_timeout_o;
   logic            flush_pipe_o;

   int checks = 0;
   int errors = 0;

   csr_commit_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .instr_valid_i(instr_valid_i), .instr_op_i(instr_op_i),
      .instr_wdata_i(instr_wdata_i), .instr_rd_i(instr_rd_i),
      .csr_addr_i(csr_addr_i), .csr_commit_o(csr_commit_o),
      .csr_req_o(csr_req_o), .csr_addr_o(csr_addr_o), .csr_op_o(csr_op_o),
      .csr_wdata_o(csr_wdata_o), .csr_rsp_valid_i(csr_rsp_valid_i),
      .csr_rdata_i(csr_rdata_i), .csr_exc_i(csr_exc_i),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .commit_ack_o(commit_ack_o), .exception_o(exception_o),
      .exc_timeout_o(exc_timeout_o), .flush_pipe_o(flush_pipe_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulses(input string tag, input logic commit, input logic ack, input logic wbv,
                         input logic exc, input logic tmo, input logic fp);
      chk({tag, ".csr_commit"},  64'(csr_commit_o),  64'(commit));
      chk({tag, ".commit_ack"},  64'(commit_ack_o),  64'(ack));
      chk({tag, ".wb_valid"},    64'(wb_valid_o),    64'(wbv));
      chk({tag, ".exception"},   64'(exception_o),   64'(exc));
      chk({tag, ".exc_timeout"}, 64'(exc_timeout_o), 64'(tmo));
      chk({tag, ".flush_pipe"},  64'(flush_pipe_o),  64'(fp));
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [11:0] addr,
                        input logic [63:0] wdata, input logic [4:0] rd);
      instr_valid_i = 1'b1;
      instr_op_i    = op;
      csr_addr_i    = addr;
      instr_wdata_i = wdata;
      instr_rd_i    = rd;
   endtask

   task automatic respond(input logic [63:0] rdata, input logic exc);
      csr_rsp_valid_i = 1'b1;
      csr_rdata_i     = rdata;
      csr_exc_i       = exc;
   endtask

   task automatic idle_inputs();
      instr_valid_i   = 1'b0;
      csr_rsp_valid_i = 1'b0;
      csr_exc_i       = 1'b0;
      flush_i         = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      idle_inputs();
      instr_op_i = 2'd0; csr_addr_i = 12'd0; instr_wdata_i = 64'd0; instr_rd_i = 5'd0;
      csr_rdata_i = 64'd0;
      #2;
      chk("rst.csr_req", 64'(csr_req_o), 64'd0);
      chk("rst.csr_addr", 64'(csr_addr_o), 64'd0);
      pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rst_ni = 1'b1;

      // READ 0xC00, rd=5, response in first REQ cycle
      issue(2'd0, 12'hC00, 64'd0, 5'd5);
      tick();
      chk("rd.req", 64'(csr_req_o), 64'd1);
      chk("rd.addr", 64'(csr_addr_o), 64'hC00);
      chk("rd.op", 64'(csr_op_o), 64'd0);
      pulses("rd.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      respond(64'h1234, 1'b0);
      tick();
      pulses("rd.done", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rd.wb_rd", 64'(wb_rd_o), 64'd5);
      chk("rd.wb_data", wb_data_o, 64'h1234);
      chk("rd.req_done", 64'(csr_req_o), 64'd0);
      idle_inputs();
      tick();
      pulses("rd.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // WRITE satp, rd=0, response after 3 cycles, then FENCE
      issue(2'd1, 12'h180, 64'h1, 5'd0);
      tick();
      chk("wr.req", 64'(csr_req_o), 64'd1);
      chk("wr.op", 64'(csr_op_o), 64'd1);
      chk("wr.wdata", csr_wdata_o, 64'h1);
      tick();
      tick();
      chk("wr.req_c3", 64'(csr_req_o), 64'd1);
      respond(64'hAA, 1'b0);
      tick();
      pulses("wr.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      csr_rsp_valid_i = 1'b0;
      issue(2'd0, 12'hC01, 64'd0, 5'd3);
      tick();
      chk("fence.req_c5", 64'(csr_req_o), 64'd0);
      pulses("fence.c5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("fence.req_c6", 64'(csr_req_o), 64'd0);
      flush_i = 1'b1;
      tick();
      chk("fence.flush", 64'(csr_req_o), 64'd0);
      flush_i = 1'b0;
      tick();
      chk("fence.accept", 64'(csr_req_o), 64'd1);
      chk("fence.addr", 64'(csr_addr_o), 64'hC01);
      respond(64'h5, 1'b0);
      tick();
      chk("fence.wb_rd", 64'(wb_rd_o), 64'd3);
      chk("fence.wb_data", wb_data_o, 64'h5);
      idle_inputs();
      tick();

      // SET 0x7C3 with wdata=0: no side effect
      issue(2'd2, 12'h7C3, 64'd0, 5'd1);
      tick();
      respond(64'h77, 1'b0);
      tick();
      pulses("set0.done", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_inputs();
      tick();

      // SET 0x7C3 with wdata=4: side effect
      issue(2'd2, 12'h7C3, 64'h4, 5'd1);
      tick();
      respond(64'h77, 1'b0);
      tick();
      pulses("set4.done", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_inputs();
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;

      // Regfile fault
      issue(2'd0, 12'h7FF, 64'd0, 5'd2);
      tick();
      respond(64'h9, 1'b1);
      tick();
      pulses("fault.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_inputs();
      tick();
      pulses("fault.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Timeout: no response, DONE at cycle 9
      issue(2'd1, 12'h340, 64'h3, 5'd4);
      tick();
      chk("tmo.req_c1", 64'(csr_req_o), 64'd1);
      for (int i = 2; i <= TIMEOUT; i++) tick();
      chk("tmo.req_c8", 64'(csr_req_o), 64'd1);
      pulses("tmo.c8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      pulses("tmo.c9", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("tmo.req_c9", 64'(csr_req_o), 64'd0);
      idle_inputs();
      tick();
      pulses("tmo.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flush in REQ with a coincident response, then a late response
      issue(2'd0, 12'hC00, 64'd0, 5'd6);
      tick();
      flush_i = 1'b1;
      respond(64'h55, 1'b0);
      tick();
      chk("flreq.req", 64'(csr_req_o), 64'd0);
      pulses("flreq.c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      flush_i = 1'b0;
      instr_valid_i = 1'b0;
      tick();
      pulses("flreq.late", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("flreq.req_late", 64'(csr_req_o), 64'd0);
      idle_inputs();
      tick();

      // Flush coincident with DONE of a side-effect write: no pulses, back to IDLE
      issue(2'd1, 12'h300, 64'h1, 5'd7);
      tick();
      respond(64'h99, 1'b0);
      tick();
      csr_rsp_valid_i = 1'b0;
      flush_i = 1'b1;
      #1;
      pulses("fldone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle_inputs();
      issue(2'd0, 12'hC02, 64'd0, 5'd5);
      tick();
      chk("fldone.idle_accept", 64'(csr_req_o), 64'd1);

      // Reset mid-REQ, then the first scenario again
      rst_ni = 1'b0;
      #1;
      chk("rstreq.req", 64'(csr_req_o), 64'd0);
      chk("rstreq.addr", 64'(csr_addr_o), 64'd0);
      chk("rstreq.wb_data", wb_data_o, 64'd0);
      pulses("rstreq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_inputs();
      #2;
      rst_ni = 1'b1;
      tick();
      issue(2'd0, 12'hC00, 64'd0, 5'd5);
      tick();
      chk("rd2.req", 64'(csr_req_o), 64'd1);
      respond(64'h1234, 1'b0);
      tick();
      pulses("rd2.done", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rd2.wb_rd", 64'(wb_rd_o), 64'd5);
      chk("rd2.wb_data", wb_data_o, 64'h1234);
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csr_commit_ctrl.md
# csr_commit_ctrl

Commit-side controller for CSR instructions. When the scoreboard head is a CSR op, it retrieves the address held by the CSR buffer and issues a single request to the CSR register file. It waits a variable latency for the response, then retires the instruction: it pulses `csr_commit_o` to release the buffer and writes back `rd`. A pipeline flush is requested when the write has architectural side effects (translation, status, or CFI landing-pad CSRs).

## Interface
Parameters:
- `XLEN`, 64, data width.
- `TIMEOUT`, 64, max cycles in WAIT before a timeout exception; must be ≥2.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush; aborts any CSR op in progress.
- `instr_valid_i` in 1: scoreboard head is a CSR op; held until `commit_ack_o` or `exception_o`.
- `instr_op_i` in 2: 0 READ, 1 WRITE, 2 SET, 3 CLEAR.
- `instr_wdata_i` in XLEN: operand, the CSR buffer result.
- `instr_rd_i` in 5: destination register.
- `csr_addr_i` in 12: address held in the CSR buffer.
- `csr_commit_o` out 1: one-cycle pulse that clears the CSR buffer entry.
- `csr_req_o` out 1: request to the CSR regfile.
- `csr_addr_o` out 12: request address.
- `csr_op_o` out 2: request op.
- `csr_wdata_o` out XLEN: request data.
- `csr_rsp_valid_i` in 1: regfile response; only meaningful while `csr_req_o`=1.
- `csr_rdata_i` in XLEN: old CSR value.
- `csr_exc_i` in 1: regfile rejected the access (illegal or privilege).
- `wb_valid_o` out 1: write back `wb_data_o` to `wb_rd_o`.
- `wb_rd_o` out 5: writeback register.
- `wb_data_o` out XLEN: writeback data.
- `commit_ack_o` out 1: instruction retired.
- `exception_o` out 1: instruction faulted; not retired.
- `exc_timeout_o` out 1: qualifies `exception_o`. 1 = timeout, 0 = regfile fault.
- `flush_pipe_o` out 1: one-cycle pulse requesting a flush after a side-effect write.

## Operation
FSM states: IDLE, REQ, DONE, FENCE.

IDLE:
- Condition: `instr_valid_i`=1 and `flush_i`=0.
- Action: latch op, addr, wdata and rd; clear the counter.
- Transition: go to REQ.

REQ:
- `csr_req_o`=1, with `csr_addr_o`, `csr_op_o` and `csr_wdata_o` driven from the latched values and held stable.
- Counter increments each cycle.
- On `csr_rsp_valid_i`:
  - Latch `csr_rdata_i` and `csr_exc_i`.
  - Go to DONE.
- If the counter reaches TIMEOUT−1 with no response:
  - Set the timeout flag.
  - Go to DONE.

DONE (exactly one cycle):
- Fault (`csr_exc_i` or timeout):
  - `exception_o`=1.
  - `exc_timeout_o` = timeout flag.
  - No `csr_commit_o`, `wb_valid_o` or `commit_ack_o`; the buffer is cleared by the ensuing flush.
  - Go to IDLE.
- Success:
  - `csr_commit_o`=1 and `commit_ack_o`=1.
  - `wb_valid_o` = (rd≠0), with `wb_data_o` = latched rdata.
  - If side-effect write: `flush_pipe_o`=1 and go to FENCE; otherwise go to IDLE.

Write effect:
- op==WRITE, or op∈{SET,CLEAR} with wdata≠0.
- READ never writes.

Side-effect addresses:
- 0x180 (satp)
- 0x300 (mstatus)
- 0x7C0–0x7CF (CFI landing-pad CSRs)

FENCE:
- Ignore `instr_valid_i` until `flush_i`=1, then go to IDLE.

`flush_i` in any state:
- Next state is IDLE; counter and timeout flag cleared.
- In DONE, `flush_i` suppresses all DONE pulses in that same cycle.
- A response arriving in the flush cycle is dropped.

## Timing
- All outputs reset to 0; state resets to IDLE, counter to 0.
- `csr_req_o` rises the cycle after acceptance in IDLE.
- A response may arrive in the first REQ cycle.
- Minimum latency: accept at cycle 0, req and rsp at cycle 1, DONE pulses at cycle 2. Next accept at cycle 3, since IDLE samples `instr_valid_i` again.
- Timeout fires with DONE at cycle TIMEOUT+1 after acceptance.
- All DONE outputs are single-cycle pulses; never two consecutive cycles.
- Counter width is `$clog2(TIMEOUT)`; it never wraps (saturates at TIMEOUT−1).
- Reset mid-REQ drops `csr_req_o` asynchronously.

## Test plan
- READ 0xC00, rd=5, rsp in first REQ cycle with rdata=0x1234 → cycle 2: `csr_commit_o`=`commit_ack_o`=`wb_valid_o`=1, `wb_rd_o`=5, `wb_data_o`=0x1234, `flush_pipe_o`=0.
- WRITE 0x180, rd=0, rsp after 3 cycles → DONE: `commit_ack_o`=1, `wb_valid_o`=0, `flush_pipe_o`=1. A further `instr_valid_i` is ignored until `flush_i`, then accepted.
- SET 0x7C3 with wdata=0 → no `flush_pipe_o`. SET 0x7C3 with wdata=0x4 → `flush_pipe_o`=1.
- Regfile returns `csr_exc_i`=1 → `exception_o`=1, `exc_timeout_o`=0, no `csr_commit_o` or `commit_ack_o`. No response for TIMEOUT=8 → `exception_o`=`exc_timeout_o`=1 at cycle 9 after acceptance.
- `flush_i` in REQ, and `flush_i` coincident with DONE → `csr_req_o` drops next cycle, zero pulses, IDLE; a late `csr_rsp_valid_i` is ignored.
- Assert `rst_ni`=0 mid-REQ → all outputs 0 immediately; the next op after reset behaves per the first scenario.
